// File: rtl/ame_pivot_ctrl.sv
// Pivot-search sequencer for the AME 6-row solver: per column read, compare, record pivot, hand off.
// Optional comparator watchdog enabled by defining AME_PIVOT_CTRL_TIMEOUT_EN.
module ame_pivot_ctrl #(
    parameter int COMP_DATA_BITS     = 64,
    parameter int COMP_DATA_IDX_BITS = 3,
    parameter int NUM_COLS           = 6
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            start_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            singular_o,
    output logic [COMP_DATA_IDX_BITS-1:0]   fail_col_o,
    output logic                            err_o,
    output logic [COMP_DATA_IDX_BITS-1:0]   col_sel_o,
    input  logic [6*COMP_DATA_BITS-1:0]     col_data_i,
    output logic                            comp_init_o,
    output logic [6*COMP_DATA_BITS-1:0]     comp_data_o,
    output logic [5:0]                      comp_data_mask_o,
    input  logic                            comp_done_i,
    input  logic [COMP_DATA_BITS-1:0]       comp_data_i,
    input  logic [COMP_DATA_IDX_BITS-1:0]   comp_data_index_i,
    output logic                            elim_req_o,
    input  logic                            elim_ack_i,
    output logic [COMP_DATA_IDX_BITS-1:0]   elim_col_o,
    output logic [COMP_DATA_IDX_BITS-1:0]   elim_row_o,
    output logic [6*COMP_DATA_IDX_BITS-1:0] pivot_rows_o
);
    localparam int ROWS = 6;
    localparam int IW   = COMP_DATA_IDX_BITS;
    localparam logic [IW-1:0] LAST_COL = IW'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_ELIM,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       col_q;
    logic [ROWS-1:0]     used_q;
    logic                singular_q;
    logic [IW-1:0]       fail_col_q;
    logic [IW-1:0]       elim_row_q;
    logic [ROWS*IW-1:0]  pivot_rows_q;
    logic                pivot_zero;
    logic                timeout;

    // A zero maximum means every unmasked candidate is zero (or all rows masked).
    assign pivot_zero = (comp_data_i == '0);

`ifdef AME_PIVOT_CTRL_TIMEOUT_EN
    logic [3:0] wait_cnt_q;
    logic       err_q;

    // Fires in the 15th consecutive WAIT cycle without a comparator answer.
    assign timeout = (state_q == S_WAIT) && !comp_done_i && (wait_cnt_q == 4'd14);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt_q <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 4'd1 : 4'd0;
            if (state_q == S_IDLE && start_i)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_LOAD;
            S_LOAD:  state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (comp_done_i)
                    state_d = pivot_zero ? S_DONE : S_ELIM;
                else if (timeout)
                    state_d = S_DONE;
            end
            S_ELIM:  if (elim_ack_i) state_d = (col_q == LAST_COL) ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_q        <= '0;
            used_q       <= '0;
            singular_q   <= 1'b0;
            fail_col_q   <= '0;
            elim_row_q   <= '0;
            pivot_rows_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        col_q        <= '0;
                        used_q       <= '0;
                        singular_q   <= 1'b0;
                        fail_col_q   <= '0;
                        pivot_rows_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (comp_done_i) begin
                        if (pivot_zero) begin
                            singular_q <= 1'b1;
                            fail_col_q <= col_q;
                        end else begin
                            for (int c = 0; c < NUM_COLS; c++)
                                if (col_q == IW'(c))
                                    pivot_rows_q[c*IW +: IW] <= comp_data_index_i;
                            used_q     <= used_q | (ROWS'(1) << comp_data_index_i);
                            elim_row_q <= comp_data_index_i;
                        end
                    end
                end
                S_ELIM: begin
                    if (elim_ack_i && col_q != LAST_COL)
                        col_q <= col_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE);
    assign comp_init_o      = (state_q == S_ISSUE);
    assign elim_req_o       = (state_q == S_ELIM);
    assign singular_o       = singular_q;
    assign fail_col_o       = fail_col_q;
    assign col_sel_o        = col_q;
    assign elim_col_o       = col_q;
    assign elim_row_o       = elim_row_q;
    assign comp_data_mask_o = used_q;
    assign comp_data_o      = col_data_i;
    assign pivot_rows_o     = pivot_rows_q;

endmodule

// File: tb/tb_ame_pivot_ctrl.sv
// Scoreboard bench for ame_pivot_ctrl: models the matrix store, comparator and elimination unit.
// Timeout scenario runs only when AME_PIVOT_CTRL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_ame_pivot_ctrl;
    localparam int W  = 64;
    localparam int IW = 3;

    logic              clk_i;
    logic              rst_n_i;
    logic              start_i;
    logic              busy_o;
    logic              done_o;
    logic              singular_o;
    logic [IW-1:0]     fail_col_o;
    logic              err_o;
    logic [IW-1:0]     col_sel_o;
    logic [6*W-1:0]    col_data_i;
    logic              comp_init_o;
    logic [6*W-1:0]    comp_data_o;
    logic [5:0]        comp_data_mask_o;
    logic              comp_done_i;
    logic [W-1:0]      comp_data_i;
    logic [IW-1:0]     comp_data_index_i;
    logic              elim_req_o;
    logic              elim_ack_i;
    logic [IW-1:0]     elim_col_o;
    logic [IW-1:0]     elim_row_o;
    logic [6*IW-1:0]   pivot_rows_o;

    ame_pivot_ctrl #(.COMP_DATA_BITS(W), .COMP_DATA_IDX_BITS(IW), .NUM_COLS(6)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .start_i           (start_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .singular_o        (singular_o),
        .fail_col_o        (fail_col_o),
        .err_o             (err_o),
        .col_sel_o         (col_sel_o),
        .col_data_i        (col_data_i),
        .comp_init_o       (comp_init_o),
        .comp_data_o       (comp_data_o),
        .comp_data_mask_o  (comp_data_mask_o),
        .comp_done_i       (comp_done_i),
        .comp_data_i       (comp_data_i),
        .comp_data_index_i (comp_data_index_i),
        .elim_req_o        (elim_req_o),
        .elim_ack_i        (elim_ack_i),
        .elim_col_o        (elim_col_o),
        .elim_row_o        (elim_row_o),
        .pivot_rows_o      (pivot_rows_o)
    );

    typedef struct { int col; logic [5:0] mask; } issue_t;
    typedef struct { int col; int row; } elim_t;
    typedef struct { int cyc; logic sing; int fcol; logic [17:0] piv; logic err; } done_t;

    issue_t exp_issue[$];
    elim_t  exp_elim[$];
    done_t  exp_done[$];

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    longint mat [6][6];
    int     ack_delay = 0;
    int     ack_wait  = 0;
    int     hs_count  = 0;
    bit     comp_hang = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    // Matrix store: column presented shortly after the edge that set col_sel_o.
    initial begin
        col_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            for (int r = 0; r < 6; r++)
                col_data_i[r*W +: W] = mat[r][col_sel_o];
        end
    end

    // Max-abs comparator with configurable latency; ties keep the lowest row.
    initial begin
        longint best;
        longint v;
        int     bidx;
        comp_done_i       = 1'b0;
        comp_data_i       = '0;
        comp_data_index_i = '0;
        forever begin
            @(negedge clk_i);
            if (comp_init_o && !comp_hang) begin
                best = 0;
                bidx = 0;
                for (int r = 0; r < 6; r++) begin
                    if (!comp_data_mask_o[r]) begin
                        v = comp_data_o[r*W +: W];
                        if (v < 0) v = -v;
                        if (v > best) begin
                            best = v;
                            bidx = r;
                        end
                    end
                end
                @(posedge clk_i);
                #1;
                comp_done_i       = 1'b1;
                comp_data_i       = best;
                comp_data_index_i = IW'(bidx);
                @(posedge clk_i);
                #1;
                comp_done_i       = 1'b0;
                comp_data_i       = '0;
                comp_data_index_i = 3'd7;
            end
        end
    end

    // Elimination unit: acknowledges after ack_delay cycles of request.
    initial begin
        elim_ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (elim_req_o) begin
                if (ack_wait >= ack_delay) begin
                    elim_ack_i = 1'b1;
                end else begin
                    elim_ack_i = 1'b0;
                    ack_wait++;
                end
            end else begin
                elim_ack_i = 1'b0;
                ack_wait   = 0;
            end
        end
    end

    // Monitor: pops expected issue/handshake/done records as the DUT presents them.
    initial begin
        issue_t      ei;
        elim_t       ee;
        done_t       ed;
        logic        req_prev;
        logic [2:0]  row_first;
        req_prev  = 1'b0;
        row_first = '0;
        forever begin
            @(negedge clk_i);
            if (comp_init_o) begin
                if (exp_issue.size() == 0) begin
                    chk("issue_unexpected", 1, 0);
                end else begin
                    ei = exp_issue.pop_front();
                    chk("issue_col", col_sel_o, ei.col);
                    chk("issue_mask", comp_data_mask_o, ei.mask);
                end
            end
            if (elim_req_o) begin
                if (!req_prev) row_first = elim_row_o;
                else chk("elim_row_stable", elim_row_o, row_first);
                if (elim_ack_i) begin
                    hs_count++;
                    if (exp_elim.size() == 0) begin
                        chk("elim_unexpected", 1, 0);
                    end else begin
                        ee = exp_elim.pop_front();
                        chk("elim_col", elim_col_o, ee.col);
                        chk("elim_row", elim_row_o, ee.row);
                    end
                end
            end
            req_prev = elim_req_o && !elim_ack_i;
            if (done_o) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    ed = exp_done.pop_front();
                    chk("done_cycle", cyc, ed.cyc);
                    chk("done_singular", singular_o, ed.sing);
                    chk("done_fail_col", fail_col_o, ed.fcol);
                    chk("done_pivot_rows", pivot_rows_o, ed.piv);
                    chk("done_err", err_o, ed.err);
                end
            end
        end
    end

    task automatic set_identity();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                mat[r][c] = (r == c) ? 64'sd5 : 64'sd1;
    endtask

    task automatic set_permuted();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                mat[r][c] = (r == 5 - c) ? -64'sd100 : longint'((r + c) % 3 + 1);
    endtask

    task automatic set_singular();
        set_identity();
        for (int r = 0; r < 6; r++) begin
            mat[r][0] = (r == 5) ? -64'sd100 : 64'sd1;
            mat[r][1] = (r == 4) ? -64'sd100 : 64'sd2;
            mat[r][2] = (r >= 4) ? 64'sd7 : 64'sd0;
        end
    endtask

    task automatic push_issue(input int col, input logic [5:0] mask);
        issue_t e;
        e.col = col; e.mask = mask;
        exp_issue.push_back(e);
    endtask

    task automatic push_elim(input int col, input int row);
        elim_t e;
        e.col = col; e.row = row;
        exp_elim.push_back(e);
    endtask

    task automatic push_done(input int c, input logic s, input int f, input logic [17:0] p, input logic e);
        done_t d;
        d.cyc = c; d.sing = s; d.fcol = f; d.piv = p; d.err = e;
        exp_done.push_back(d);
    endtask

    task automatic start_run(output int t0);
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        t0      = cyc;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic pulse_start_after(input int n);
        repeat (n) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            if (!busy_o) break;
            @(posedge clk_i);
            #1;
        end
        chk(name, busy_o, 0);
    endtask

    task automatic check_drained(input string name);
        chk({name, "_issue_left"}, exp_issue.size(), 0);
        chk({name, "_elim_left"}, exp_elim.size(), 0);
        chk({name, "_done_left"}, exp_done.size(), 0);
    endtask

    function automatic logic [41:0] all_outputs();
        return {busy_o, done_o, singular_o, fail_col_o, err_o, col_sel_o, comp_init_o,
                comp_data_mask_o, elim_req_o, elim_col_o, elim_row_o, pivot_rows_o};
    endfunction

    logic [5:0] id_masks   [6] = '{6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111};
    logic [5:0] perm_masks [6] = '{6'b000000, 6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b111110};

    initial begin
        int t0;
        int hs_before;
        int found;
        rst_n_i = 1'b0;
        start_i = 1'b0;
        set_identity();
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_outputs", all_outputs(), 0);
        rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // identity-like matrix, immediate ack, stray start mid-run
        set_identity();
        ack_delay = 0;
        for (int c = 0; c < 6; c++) begin
            push_issue(c, id_masks[c]);
            push_elim(c, c);
        end
        start_run(t0);
        push_done(t0 + 25, 1'b0, 0, 18'o543210, 1'b0);
        pulse_start_after(8);
        wait_idle("ident_idle");
        chk("ident_busy_fall", cyc - t0, 26);
        chk("ident_pivot_rows", pivot_rows_o, 18'o543210);
        check_drained("ident");

        // permuted pivots
        set_permuted();
        for (int c = 0; c < 6; c++) begin
            push_issue(c, perm_masks[c]);
            push_elim(c, 5 - c);
        end
        start_run(t0);
        push_done(t0 + 25, 1'b0, 0, 18'o012345, 1'b0);
        wait_idle("perm_idle");
        check_drained("perm");

        // singular at column 2
        set_singular();
        hs_before = hs_count;
        push_issue(0, 6'b000000);
        push_issue(1, 6'b100000);
        push_issue(2, 6'b110000);
        push_elim(0, 5);
        push_elim(1, 4);
        start_run(t0);
        push_done(t0 + 12, 1'b1, 2, 18'o000045, 1'b0);
        wait_idle("sing_idle");
        repeat (3) @(posedge clk_i);
        #1;
        chk("sing_handshakes", hs_count - hs_before, 2);
        chk("sing_held", singular_o, 1);
        chk("sing_fail_col_held", fail_col_o, 2);
        check_drained("sing");

        // backpressure: ack three cycles late
        set_identity();
        ack_delay = 3;
        for (int c = 0; c < 6; c++) begin
            push_issue(c, id_masks[c]);
            push_elim(c, c);
        end
        start_run(t0);
        push_done(t0 + 43, 1'b0, 0, 18'o543210, 1'b0);
        wait_idle("bp_idle");
        chk("bp_busy_fall", cyc - t0, 44);
        check_drained("bp");
        ack_delay = 0;

        // reset during column 3 WAIT
        for (int c = 0; c < 4; c++) push_issue(c, id_masks[c]);
        for (int c = 0; c < 3; c++) push_elim(c, c);
        start_run(t0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i);
            #1;
            if (comp_init_o && col_sel_o == 3'd3) begin
                found = 1;
                break;
            end
        end
        chk("rst_reach_col3", found, 1);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("rst_outputs_zero", all_outputs(), 0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_still_zero", all_outputs(), 0);
        rst_n_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check_drained("rst");
        for (int c = 0; c < 6; c++) begin
            push_issue(c, id_masks[c]);
            push_elim(c, c);
        end
        start_run(t0);
        push_done(t0 + 25, 1'b0, 0, 18'o543210, 1'b0);
        wait_idle("rerun_idle");
        check_drained("rerun");

`ifdef AME_PIVOT_CTRL_TIMEOUT_EN
        // comparator never answers
        comp_hang = 1'b1;
        push_issue(0, 6'b000000);
        start_run(t0);
        push_done(t0 + 18, 1'b0, 0, 18'o0, 1'b1);
        pulse_start_after(4);
        wait_idle("tmo_idle");
        chk("tmo_err_held", err_o, 1);
        repeat (3) @(posedge clk_i);
        #1;
        check_drained("tmo");
        comp_hang = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/ame_pivot_ctrl.md
# ame_pivot_ctrl

Sequencing controller for the AME 6-row linear-system solver's pivot search. For each column in turn it reads the column from the matrix store, drives the shared 6-input max-abs comparator (`ame_num_compare`) with a mask of rows already used as pivots, records the winning row, and hands that pivot to the elimination unit with a req/ack handshake. It sits between the solver top-level FSM, the matrix store, the comparator and the elimination datapath. It reports completion, the full pivot permutation, and singularity.

## Interface
- `COMP_DATA_BITS`, 64, element width; must match the comparator.
- `COMP_DATA_IDX_BITS`, 3, row/column index width.
- `NUM_COLS`, 6, columns to pivot; legal range 1..6.

- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `singular_o`  out  1  set when a column has no non-zero unmasked candidate; held until next start.
- `fail_col_o`  out  COMP_DATA_IDX_BITS  column that caused singularity; valid with `singular_o`.
- `err_o`  out  1  comparator timeout; see Configuration.
- `col_sel_o`  out  COMP_DATA_IDX_BITS  column address to the matrix store; store read latency is 1 cycle.
- `col_data_i`  in  6×COMP_DATA_BITS  column data from the store.
- `comp_init_o`  out  1  comparator start.
- `comp_data_o`  out  6×COMP_DATA_BITS  comparator operands; combinational pass-through of `col_data_i`.
- `comp_data_mask_o`  out  6  comparator mask; the used-row register.
- `comp_done_i`  in  1  comparator done.
- `comp_data_i`  in  COMP_DATA_BITS  comparator max |value|.
- `comp_data_index_i`  in  COMP_DATA_IDX_BITS  comparator winning row.
- `elim_req_o`  out  1  pivot valid to the elimination unit.
- `elim_ack_i`  in  1  elimination unit accepts the pivot.
- `elim_col_o`  out  COMP_DATA_IDX_BITS  current column; equals `col_sel_o`.
- `elim_row_o`  out  COMP_DATA_IDX_BITS  pivot row of the current column.
- `pivot_rows_o`  out  6×COMP_DATA_IDX_BITS  pivot row per column; entry c is valid once column c has been accepted.

## Operation
FSM states and transitions:
- **IDLE**: `start_i` → LOAD. On entry to LOAD: column counter = 0, used mask = 0, `singular_o` = 0, `fail_col_o` = 0, `err_o` = 0, `pivot_rows_o` = 0.
- **LOAD**: 1 cycle covering the store read latency → ISSUE.
- **ISSUE**: `comp_init_o` = 1 for exactly 1 cycle → WAIT.
- **WAIT**: waits for `comp_done_i`.
  - If `comp_data_i` == 0: set `singular_o`, set `fail_col_o` = current column, → DONE. No elimination request is made.
  - Otherwise: `pivot_rows_o[col]` = `comp_data_index_i`, set used mask bit `comp_data_index_i`, latch `elim_row_o`, → ELIM.
- **ELIM**: `elim_req_o` = 1 and held until `elim_ack_i`. On ack: if col == NUM_COLS-1 → DONE, else col+1 → LOAD.
- **DONE**: `done_o` = 1 for 1 cycle → IDLE.

Rules:
- The zero test always takes precedence. The index returned for an all-masked or all-zero column is never recorded.
- `start_i` is ignored outside IDLE.
- `comp_done_i` is ignored outside WAIT.
- `elim_ack_i` is ignored outside ELIM.
- All outputs are registered or Moore-decoded, except `comp_data_o`.
- Reset values: every output 0; the FSM returns to IDLE.
- Reset mid-operation: the FSM returns to IDLE asynchronously, with no `done_o` and no `elim_req_o` afterwards.

## Timing
Cycle 0 is the cycle in which `start_i` is sampled. Column c (0-based) with a 1-cycle comparator and immediate ack:
- LOAD at cycle 1+4c.
- ISSUE at cycle 2+4c.
- WAIT at cycle 3+4c.
- ELIM at cycle 4+4c.

End of run:
- For NUM_COLS = 6, `done_o` is high in cycle 25 and `busy_o` is low from cycle 26.
- Each cycle of delayed `elim_ack_i` adds 1 cycle.
- Each extra cycle of comparator latency adds 1 cycle.
- Singularity at column c: `done_o` is high in cycle 4+4c.

## Configuration
- **`AME_PIVOT_CTRL_TIMEOUT_EN` defined**: a 4-bit counter runs in WAIT. If `comp_done_i` has not arrived after 15 WAIT cycles, the controller sets `err_o` and goes to DONE (`done_o` pulses). `err_o` is held until the next start.
- **Not defined**: no counter; WAIT waits indefinitely and `err_o` is tied to 0.

## Test plan
- **Identity-like matrix**: diagonal = 5, all other entries 1; immediate ack; 1-cycle comparator → `pivot_rows_o` = {0,1,2,3,4,5}, `done_o` in cycle 25, `singular_o` = 0.
- **Permuted pivots**: column c has its largest |value| (−100) in row 5−c → `pivot_rows_o` = {5,4,3,2,1,0}; `comp_data_mask_o` before column 3 = 6'b111000.
- **Singular matrix**: column 2 is zero in all unused rows → `singular_o` = 1, `fail_col_o` = 2, `done_o` in cycle 12, only two `elim_req_o` handshakes occur.
- **Backpressure**: `elim_ack_i` delayed 3 cycles on every column → `elim_req_o` held steady with stable `elim_row_o`; `done_o` in cycle 43.
- **Reset mid-run**: `rst_n_i` asserted during column 3 WAIT → all outputs 0 immediately; a subsequent `start_i` runs cleanly from column 0.
- **Timeout** (with `AME_PIVOT_CTRL_TIMEOUT_EN`): comparator never asserts done → `err_o` = 1 and `done_o` pulse 16 cycles after ISSUE; `start_i` during the run is ignored.
